cond_pipe_unit: RTL and testbench
=================================

// Module: cond_pipe_unit
// PURPOSE
//  Pipelined, width-parametrised branch-condition unit for the model CPU datapath.
//  Compares two operands under an 8-bit condition code and returns a 1-bit taken/not-taken result.
//  Adds signed compares, result inversion and a sticky condition flag.
//  Connects via valid/ready handshakes between operand fetch and the PC-update logic.
// PARAMETERS
//  WIDTH      8   operand width in bits, >= 2
//  FLAG_INIT  0   reset value of FLAG
// PORTS
//  CLK        input   1      clock, all state updates on rising edge
//  RST_N      input   1      asynchronous active-low reset
//  IN_VALID   input   1      CONDITION/INPUT1/INPUT2 valid this cycle
//  IN_READY   output  1      unit accepts an input this cycle
//  CONDITION  input   8      condition code (encoding below)
//  INPUT1     input   WIDTH  first operand
//  INPUT2     input   WIDTH  second operand
//  OUT_VALID  output  1      OUTPUT holds a valid result
//  OUT_READY  input   1      consumer takes OUTPUT this cycle
//  OUTPUT     output  1      comparison result
//  FLAG       output  1      sticky last-result flag
// BEHAVIOUR
//  CONDITION[7]=flag-write, [6]=invert, [5]=enable, [4:0]=op.
//  Op codes:
//   0 EQ, 1 NE, 2 ULT, 3 ULE, 4 UGT, 5 UGE: unsigned compares.
//   6 SLT, 7 SLE, 8 SGT, 9 SGE: two's-complement compares on WIDTH bits.
//   10 FLAG: raw = current FLAG.
//   11..31: raw = 0.
//  Result rules:
//   enable=0 -> raw=0 and the invert bit is ignored, so the result is 0.
//   enable=1 -> result = raw ^ CONDITION[6].
//  Pipeline: two register stages, S1 (operand capture) and S2 (result).
//   adv = !OUT_VALID | OUT_READY, combinational.
//   IN_READY = adv. An input is accepted when IN_VALID & IN_READY.
//   When adv=1:
//    S1 loads {IN_VALID, CONDITION, INPUT1, INPUT2}.
//    S2 loads {S1.valid, result computed from S1}.
//   When adv=0: both stages hold and IN_READY=0.
//  OUT_VALID = S2.valid. OUTPUT = S2 result; OUTPUT is 0 whenever OUT_VALID=0.
//  Latency: 2 cycles from accept to OUT_VALID when there is no back-pressure.
//  Throughput: 1 result per cycle under continuous OUT_READY=1.
//  Bubbles: S1.valid=0 propagates as a bubble; OUTPUT is 0 for that slot.
//  FLAG update:
//   FLAG <= result on the edge where S1 moves into S2 (adv & S1.valid & S1.cond[7]).
//   FLAG holds otherwise.
//  Op 10 timing: it reads FLAG as registered at the S1->S2 edge.
//   Back-to-back flag-write followed by op 10 therefore sees the new value (forwarding).
//   The forwarded value is the result of the prior stage-2 write.
//   Forwarding is done with a bypass mux, not an extra stage.
//  Reset (RST_N low, asynchronous):
//   S1.valid=0, S2.valid=0, OUTPUT=0, OUT_VALID=0, FLAG=FLAG_INIT, stored operands=0.
//   IN_READY=1 while RST_N is low and in the first cycle after release.
//  Reset mid-operation: in-flight entries are discarded and are never presented after release.
//  Signed compares: MSB is the sign bit. Example for WIDTH=8: 0x80 < 0x7F.
//  Equal operands: LE/GE give 1; LT/GT give 0, both signed and unsigned.
// TESTING
//  T1 Reset value: release RST_N with FLAG_INIT=0.
//   -> OUT_VALID=0, OUTPUT=0, FLAG=0, IN_READY=1.
//  T2 Op sweep: W=8, in1=0x80, in2=0x7F, ops 0..11 with enable=1, invert=0.
//   -> results 0,1,0,0,1,1,1,1,0,0,FLAG,0.
//   -> Each result appears exactly 2 cycles after accept.
//  T3 Invert/enable: cond=0x60 (EQ, invert, enable) on 5,5 -> 0.
//   -> cond=0x40 (invert, no enable) -> 0.
//  T4 Back-pressure: stream 4 inputs with OUT_READY low for 3 cycles mid-stream.
//   -> IN_READY=0 during the stall.
//   -> No result is lost or duplicated; results come out in order.
//  T5 Flag forwarding: cond=0xA2 (ULT, flag-write) on 1,2, then cond=0x2A (op FLAG) back-to-back.
//   -> First result 1, FLAG=1, second result 1.
//  T6 Reset mid-stream: assert RST_N low with both stages valid.
//   -> OUT_VALID=0 immediately (async); no stale result after release; WIDTH=16 variant passes T2.

Source files
------------

// File: rtl/cond_pipe_unit.sv
// rtl/cond_pipe_unit.sv - two-stage pipelined branch-condition unit with sticky flag
// Operands are captured in S1, the taken/not-taken result is registered in S2.
module cond_pipe_unit #(
   parameter int WIDTH     = 8,
   parameter bit FLAG_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       condition,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic             flag
);

   logic             adv;
   logic             s1_valid;
   logic [7:0]       s1_cond;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s2_valid;
   logic             s2_res;
   logic             s2_fwd;
   logic             flag_byp;
   logic             raw;
   logic             s1_result;

   assign adv       = !s2_valid | out_ready;
   assign in_ready  = adv;
   assign out_valid = s2_valid;
   assign result    = s2_valid & s2_res;

   // Bypass: when S2 holds a flag-writing entry its result is the newest flag value.
   assign flag_byp = s2_fwd ? s2_res : flag;

   always_comb begin
      raw = 1'b0;
      case (s1_cond[4:0])
         5'd0:    raw = (s1_a == s1_b);
         5'd1:    raw = (s1_a != s1_b);
         5'd2:    raw = (s1_a <  s1_b);
         5'd3:    raw = (s1_a <= s1_b);
         5'd4:    raw = (s1_a >  s1_b);
         5'd5:    raw = (s1_a >= s1_b);
         5'd6:    raw = ($signed(s1_a) <  $signed(s1_b));
         5'd7:    raw = ($signed(s1_a) <= $signed(s1_b));
         5'd8:    raw = ($signed(s1_a) >  $signed(s1_b));
         5'd9:    raw = ($signed(s1_a) >= $signed(s1_b));
         5'd10:   raw = flag_byp;
         default: raw = 1'b0;
      endcase
      // A disabled condition is never taken, whatever the invert bit says.
      s1_result = s1_cond[5] & (raw ^ s1_cond[6]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_cond  <= 8'd0;
         s1_a     <= '0;
         s1_b     <= '0;
         s2_valid <= 1'b0;
         s2_res   <= 1'b0;
         s2_fwd   <= 1'b0;
         flag     <= FLAG_INIT;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_cond  <= condition;
         s1_a     <= input1;
         s1_b     <= input2;
         s2_valid <= s1_valid;
         s2_res   <= s1_valid & s1_result;
         s2_fwd   <= s1_valid & s1_cond[7];
         if (s1_valid && s1_cond[7])
            flag <= s1_result;
      end
   end

endmodule

// File: tb/tb_cond_pipe_unit.sv
// tb/tb_cond_pipe_unit.sv - scoreboard bench for cond_pipe_unit at WIDTH 8 and 16
// The 16-bit copy sees the 8-bit operands shifted left by 8, which preserves every ordering.
module tb_cond_pipe_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] condition;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_ready;
   logic       in_ready8, out_valid8, result8, flag8;
   logic       in_ready16, out_valid16, result16, flag16;

   cond_pipe_unit #(.WIDTH(8), .FLAG_INIT(1'b0)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
      .condition(condition), .input1(a), .input2(b),
      .out_valid(out_valid8), .out_ready(out_ready), .result(result8), .flag(flag8)
   );

   cond_pipe_unit #(.WIDTH(16), .FLAG_INIT(1'b0)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .condition(condition), .input1({a, 8'h00}), .input2({b, 8'h00}),
      .out_valid(out_valid16), .out_ready(out_ready), .result(result16), .flag(flag16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit exp;
      int acc;
      bit chk_lat;
   } sb_t;

   typedef struct {
      logic [7:0] c;
      logic [7:0] x;
      logic [7:0] y;
      bit         e;
   } vec_t;

   sb_t  q[$];
   vec_t tab[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mflag = 1'b0;
   bit   lat_mode = 1'b0;
   bit   pend_exp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y,
                                input bit f);
      logic [7:0] xs, ys;
      bit r;
      xs = x ^ 8'h80;
      ys = y ^ 8'h80;
      case (c[4:0])
         5'd0:    r = (x == y);
         5'd1:    r = (x != y);
         5'd2:    r = (x < y);
         5'd3:    r = !(y < x);
         5'd4:    r = (y < x);
         5'd5:    r = !(x < y);
         5'd6:    r = (xs < ys);
         5'd7:    r = !(ys < xs);
         5'd8:    r = (ys < xs);
         5'd9:    r = !(xs < ys);
         5'd10:   r = f;
         default: r = 1'b0;
      endcase
      if (!c[5]) return 1'b0;
      return r ^ c[6];
   endfunction

   task automatic drive(input bit v, input logic [7:0] c, input logic [7:0] x,
                        input logic [7:0] y, input bit e);
      in_valid  = v;
      condition = c;
      a         = x;
      b         = y;
      pend_exp  = e;
   endtask

   // Called just after a falling edge; settles, records handshakes, then advances one cycle.
   task automatic tick(output bit accepted);
      sb_t s;
      #1;
      accepted = in_valid && in_ready8;
      if (accepted) begin
         q.push_back('{pend_exp, cyc, lat_mode});
         if (condition[7]) mflag = pend_exp;
      end
      if (!out_ready && out_valid8) check("stall_in_ready", in_ready8, 0);
      if (!out_valid8) check("bubble_zero", result8, 0);
      if (out_valid8 && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            s = q.pop_front();
            check("result8", result8, s.exp);
            check("valid16", out_valid16, 1);
            check("result16", result16, s.exp);
            if (s.chk_lat) check("latency", cyc - s.acc, 2);
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick(acc);
   endtask

   task automatic run_table();
      bit acc;
      lat_mode = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < tab.size(); i++) begin
         drive(1'b1, tab[i].c, tab[i].x, tab[i].y, tab[i].e);
         tick(acc);
         check("table_accept", acc, 1);
      end
      idle(4);
      check("table_drained", q.size(), 0);
      lat_mode = 1'b0;
   endtask

   task automatic run_stream(input int n, input int st, input int len, input int period);
      bit acc;
      int base, guard;
      logic [7:0] c, x, y;
      base = cyc;
      for (int i = 0; i < n; i++) begin
         c = {($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 5) != 0), 5'($urandom_range(0, 13))};
         x = 8'($urandom);
         y = ($urandom_range(0, 3) == 0) ? x : 8'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            out_ready = !((((cyc - base) % period) >= st) && (((cyc - base) % period) < st + len));
            drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
            tick(acc);
         end
         drive(1'b1, c, x, y, model(c, x, y, mflag));
         acc = 1'b0;
         guard = 0;
         while (!acc && guard < 20) begin
            out_ready = !((((cyc - base) % period) >= st) && (((cyc - base) % period) < st + len));
            tick(acc);
            guard++;
         end
         if (!acc) check("stream_accept_timeout", 0, 1);
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         tick(acc);
         guard++;
      end
      check("stream_drained", q.size(), 0);
   endtask

   initial begin
      bit acc;
      rst_n = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      #3;
      check("rst_out_valid", out_valid8, 0);
      check("rst_in_ready", in_ready8, 1);
      check("rst_flag", flag8, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_out_valid", out_valid8, 0);
      check("rel_result", result8, 0);
      check("rel_flag", flag8, 0);
      check("rel_in_ready", in_ready8, 1);
      @(negedge clk);

      // 0x80 vs 0x7F sweep, equal-operand boundaries, invert/enable handling
      for (int op = 0; op < 12; op++)
         tab.push_back('{8'h20 | 8'(op), 8'h80, 8'h7F, 1'b0});
      tab[1].e = 1'b1; tab[4].e = 1'b1; tab[5].e = 1'b1; tab[6].e = 1'b1; tab[7].e = 1'b1;
      tab.push_back('{8'h22, 8'h05, 8'h05, 1'b0});
      tab.push_back('{8'h23, 8'h05, 8'h05, 1'b1});
      tab.push_back('{8'h24, 8'h05, 8'h05, 1'b0});
      tab.push_back('{8'h25, 8'h05, 8'h05, 1'b1});
      tab.push_back('{8'h26, 8'hF0, 8'hF0, 1'b0});
      tab.push_back('{8'h29, 8'hF0, 8'hF0, 1'b1});
      tab.push_back('{8'h60, 8'h05, 8'h05, 1'b0});
      tab.push_back('{8'h40, 8'h05, 8'h05, 1'b0});
      tab.push_back('{8'h41, 8'h05, 8'h06, 1'b0});
      tab.push_back('{8'h6C, 8'h01, 8'h02, 1'b1});
      run_table();

      // flag-write then op FLAG back to back, first writing 1 then writing 0
      out_ready = 1'b1;
      lat_mode = 1'b1;
      drive(1'b1, 8'hA2, 8'h01, 8'h02, 1'b1);
      tick(acc);
      drive(1'b1, 8'h2A, 8'h00, 8'h00, 1'b1);
      tick(acc);
      check("fwd_flag8", flag8, 1);
      check("fwd_flag16", flag16, 1);
      drive(1'b1, 8'hA2, 8'h02, 8'h01, 1'b0);
      tick(acc);
      drive(1'b1, 8'h2A, 8'h00, 8'h00, 1'b0);
      tick(acc);
      drive(1'b1, 8'h6A, 8'h00, 8'h00, 1'b1);
      tick(acc);
      idle(4);
      check("fwd_flag_cleared", flag8, 0);
      lat_mode = 1'b0;

      // four inputs with a three-cycle consumer stall, then a long stalled random stream
      run_stream(4, 2, 3, 1000);
      run_stream(60, 0, 2, 7);

      // reset with both stages holding valid entries
      out_ready = 1'b0;
      drive(1'b1, 8'hA1, 8'h01, 8'h02, 1'b1);
      tick(acc);
      drive(1'b1, 8'h21, 8'h03, 8'h04, 1'b1);
      tick(acc);
      in_valid = 1'b0;
      #2;
      check("pre_rst_out_valid", out_valid8, 1);
      rst_n = 1'b0;
      #1;
      check("async_out_valid8", out_valid8, 0);
      check("async_out_valid16", out_valid16, 0);
      check("async_result", result8, 0);
      check("async_in_ready", in_ready8, 1);
      check("async_flag", flag8, 0);
      q.delete();
      mflag = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(5);
      run_table();
      run_stream(20, 1, 2, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
